// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and default width for serial_adder
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// rtl/serial_adder_full_adder_cell.sv - single-bit full adder used by the serial datapath
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one bit per clock LSB-first
// SERIAL_ADDER_OVF_EN adds a signed overflow output.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_r;
   logic             carry_r;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;

   full_adder_cell u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry_r),
      .s    (fa_s),
      .cout (fa_c)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            if (last_bit) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_r <= 1'b0;
            cnt     <= '0;
         end else if (state == RUN) begin
            // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            sum_r   <= {fa_s, sum_r[WIDTH-1:1]};
            carry_r <= fa_c;
            cnt     <= cnt + CW'(1);
         end
      end
   end

   assign sum       = sum_r;
   assign carry_out = carry_r;

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_r;

   // On the MSB step carry_r is the carry into the MSB and fa_c the carry out of it.
   always_ff @(posedge clk) begin
      if (!rst_n)
         ovf_r <= 1'b0;
      else if (state == RUN && last_bit)
         ovf_r <= carry_r ^ fa_c;
   end

   assign overflow = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder (optional SERIAL_ADDER_OVF_EN)
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;
`ifdef SERIAL_ADDER_OVF_EN
   logic         overflow;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .overflow  (overflow)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer addition, then split into result, carry and signed overflow.
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned t;
      t = int'(x) + int'(y);
      return t[W:0];
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
      int sx, sy, s;
      sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
      sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
      s  = sx + sy;
      return (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
   endfunction

   task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input int hold, input bit glitch, input string tag);
      logic [W:0]   exp;
      logic [W-1:0] s0;
      logic         c0;
      int           lat;
      exp = ref_add(ai, bi);
      lat = 0;
      while (!in_ready && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      a = ai;
      b = bi;
      tick();
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin
         if (glitch && lat == 3) begin
            in_valid = 1'b1;
            a = 8'hAA;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (!out_valid) lat++;
      end
      in_valid = 1'b0;
      check({tag, "_lat"}, lat, W);
      check({tag, "_sum"}, sum, exp[W-1:0]);
      check({tag, "_cout"}, carry_out, exp[W]);
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, overflow, ref_ovf(ai, bi));
`endif
      s0 = sum;
      c0 = carry_out;
      for (int i = 0; i < hold; i++) begin
         in_valid = ($urandom_range(0, 1) == 1);
         tick();
         check({tag, "_hold_ov"}, out_valid, 1'b1);
         check({tag, "_hold_ir"}, in_ready, 1'b0);
         check({tag, "_hold_sum"}, {c0, s0}, {carry_out, sum});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle_ir"}, in_ready, 1'b1);
      check({tag, "_idle_ov"}, out_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_t[2];
      int n_acc;
      int n_res;
      bit seen;
      logic [W:0] exp_r[2];

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      tick(); tick();
      check("rst_ir", in_ready, 1'b1);
      check("rst_ov", out_valid, 1'b0);
      check("rst_sum", sum, 0);
      check("rst_cout", carry_out, 1'b0);
      rst_n = 1'b1;
      tick();

      run_op(8'h05, 8'h03, 0, 1'b0, "d05_03");
      run_op(8'hFF, 8'h01, 0, 1'b0, "dFF_01");
      run_op(8'h7F, 8'h01, 5, 1'b0, "d7F_01_hold");
      run_op(8'h05, 8'h03, 1, 1'b1, "glitch");

      // Reset on the fourth RUN edge discards the operation.
      in_valid = 1'b1; a = 8'h55; b = 8'h66;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_ir", in_ready, 1'b1);
      check("mrst_ov", out_valid, 1'b0);
      check("mrst_sum", sum, 0);
      check("mrst_cout", carry_out, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
      check("mrst_ovf", overflow, 1'b0);
`endif
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("mrst_no_ov", seen, 1'b0);
      run_op(8'h10, 8'h20, 0, 1'b0, "post_rst");

      // Back-to-back with in_valid held and out_ready high.
      exp_r[0] = ref_add(8'h05, 8'h03);
      exp_r[1] = ref_add(8'h80, 8'h80);
      n_acc = 0; n_res = 0;
      in_valid = 1'b1; a = 8'h05; b = 8'h03; out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (in_ready && in_valid && n_acc < 2) begin
            acc_t[n_acc] = c;
            n_acc++;
         end
         if (out_valid && n_res < 2) begin
            check("b2b_sum", {carry_out, sum}, exp_r[n_res]);
            n_res++;
         end
         tick();
         if (n_acc == 1) begin a = 8'h80; b = 8'h80; end
         if (n_acc == 2) in_valid = 1'b0;
      end
      out_ready = 1'b0;
      check("b2b_nacc", n_acc, 2);
      check("b2b_nres", n_res, 2);
      if (n_acc == 2) check("b2b_space", acc_t[1] - acc_t[0], W + 2);

      for (int k = 0; k < 20; k++)
         run_op(W'($urandom), W'($urandom), $urandom_range(0, 3), $urandom_range(0, 1), "rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
